// File: rtl/ysyx_041514_icache_data_array.sv
// ysyx_041514_icache_data_array
//   Banked N-way icache data array with its own line-fill sequencer. The
//   tag/control FSM issues one fetch read per cycle, and the 32-bit word
//   comes back one cycle later. The AXI refill path streams beats in, and
//   each beat is written into a 64x128 bit-write-enable SRAM macro.
//
//   Optional feature: define YSYX_041514_ICACHE_FWD_EN to add a line buffer.
//   While a fill is in progress, this buffer serves reads of beats that have
//   already arrived.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rd_valid_i / rd_ready_o  fetch read handshake
//   rd_way_i, rd_index_i     way (from tag hit) and set index
//   rd_blk_i                 byte offset within the line; bits [1:0] ignored
//   rdata_valid_o, rdata_o   read result one cycle after acceptance,
//                            {zeros, instr}
//   fill_start_i             begin refill of (fill_way_i, fill_index_i)
//   fill_valid_i/fill_ready_o  refill beat handshake; fill_data_i is the beat
//   fill_busy_o              sequencer not idle
//   fill_done_o              one-cycle pulse after the last beat is written

`ifndef ysyx_041514_XLEN_BUS
`define ysyx_041514_XLEN_BUS 63:0
`endif

// Behavioural model of the 64x128 single-port SRAM macro. It has the same
// pinout as S011HD1P_X32Y2D128_BW. CEN, WEN and BWEN are active low.
// Q updates only on a read.
module ysyx_041514_icache_sram (
   input  logic         clk,
   input  logic         cen,
   input  logic         wen,
   input  logic [127:0] bwen,
   input  logic [5:0]   a,
   input  logic [127:0] d,
   output logic [127:0] q
);
   logic [127:0] mem [64];

   always_ff @(posedge clk) begin
      if (!cen) begin
         if (!wen) mem[a] <= (mem[a] & bwen) | (d & ~bwen);
         else      q      <= mem[a];
      end
   end
endmodule

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no fill; reads are served from the macros
// FILL  | accepting refill beats into the latched way/index
// DONE  | last beat written; fill_done_o pulses, then back to IDLE
module ysyx_041514_icache_data_array #(
   parameter  int WAYS    = 2,
   parameter  int IDX_LEN = 6,
   parameter  int BLK_LEN = 6,
   parameter  int BEAT_W  = 64,
   localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rd_valid_i,
   output logic                       rd_ready_o,
   input  logic [WAY_W-1:0]           rd_way_i,
   input  logic [IDX_LEN-1:0]         rd_index_i,
   input  logic [BLK_LEN-1:0]         rd_blk_i,
   output logic                       rdata_valid_o,
   output logic [`ysyx_041514_XLEN_BUS] rdata_o,
   input  logic                       fill_start_i,
   input  logic [WAY_W-1:0]           fill_way_i,
   input  logic [IDX_LEN-1:0]         fill_index_i,
   input  logic                       fill_valid_i,
   output logic                       fill_ready_o,
   input  logic [BEAT_W-1:0]          fill_data_i,
   output logic                       fill_busy_o,
   output logic                       fill_done_o
);
   localparam int NBANK    = (2**BLK_LEN) * 8 / 128;
   localparam int BANK_W   = (NBANK > 1) ? $clog2(NBANK) : 1;
   localparam int BEATS    = (2**BLK_LEN) * 8 / BEAT_W;
   localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SUB      = 128 / BEAT_W;
   localparam int SUB_W    = (SUB > 1) ? $clog2(SUB) : 1;
   localparam int BEAT_LOG = $clog2(BEAT_W / 8);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   beat_cnt_q;
   logic [WAY_W-1:0]   fill_way_q;
   logic [IDX_LEN-1:0] fill_idx_q;

   logic fill_fire, rd_fire, rd_mem, fill_accept, fwd_hit;

   assign fill_fire   = fill_valid_i & fill_ready_o;
   assign rd_fire     = rd_valid_i & rd_ready_o;
   assign fill_accept = (state_q == S_IDLE) & fill_start_i;
   // Only IDLE reads touch the macros; any read accepted during FILL comes
   // from the line buffer, so a macro is never read and written together.
   assign rd_mem      = rd_fire & (state_q == S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (fill_start_i) state_d = S_FILL;
         S_FILL:  if (fill_fire && beat_cnt_q == CNT_W'(BEATS - 1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // An IDLE fill request has priority over a read in the same cycle.
   always_comb begin
      fill_ready_o = 1'b0;
      fill_busy_o  = 1'b1;
      fill_done_o  = 1'b0;
      rd_ready_o   = 1'b0;
      case (state_q)
         S_IDLE: begin
            fill_busy_o = 1'b0;
            rd_ready_o  = ~fill_start_i;
         end
         S_FILL: begin
            fill_ready_o = 1'b1;
            rd_ready_o   = fwd_hit;
         end
         S_DONE:  fill_done_o = 1'b1;
         default: ;
      endcase
   end

   // The beat counter wraps to 0 naturally on the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q <= '0;
         fill_way_q <= '0;
         fill_idx_q <= '0;
      end else if (fill_accept) begin
         beat_cnt_q <= '0;
         fill_way_q <= fill_way_i;
         fill_idx_q <= fill_index_i;
      end else if (fill_fire) begin
         beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
   end

   // A beat lands in bank beat/SUB, in the BEAT_W slice beat%SUB of that bank.
   logic [BANK_W-1:0]  wr_bank;
   logic [SUB_W-1:0]   wr_slice;
   logic [127:0]       wr_bwen_n;
   logic [127:0]       wr_d;
   logic [IDX_LEN-1:0] mem_addr;

   assign wr_bank  = BANK_W'(int'(beat_cnt_q) / SUB);
   assign wr_slice = SUB_W'(int'(beat_cnt_q) % SUB);
   assign wr_d     = {SUB{fill_data_i}};
   assign mem_addr = (state_q == S_FILL) ? fill_idx_q : rd_index_i;

   always_comb begin
      wr_bwen_n = '1;
      wr_bwen_n[wr_slice*BEAT_W +: BEAT_W] = '0;
   end

   logic [127:0] bank_q [WAYS][NBANK];

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      for (genvar b = 0; b < NBANK; b++) begin : g_bank
         logic wr_sel;
         assign wr_sel = fill_fire && (fill_way_q == WAY_W'(w)) && (wr_bank == BANK_W'(b));

         ysyx_041514_icache_sram u_sram (
            .clk  (clk),
            .cen  (~(wr_sel | rd_mem)),
            .wen  (~wr_sel),
            .bwen (wr_bwen_n),
            .a    (mem_addr),
            .d    (wr_d),
            .q    (bank_q[w][b])
         );
      end
   end

   logic              rvalid_q;
   logic [WAY_W-1:0]  rway_q;
   logic [BANK_W-1:0] rbank_q;
   logic [1:0]        rword_q;
   logic [31:0]       mem_word, rd_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rway_q   <= '0;
         rbank_q  <= '0;
         rword_q  <= '0;
      end else begin
         rvalid_q <= rd_fire;
         if (rd_fire) begin
            rway_q  <= rd_way_i;
            rbank_q <= BANK_W'(rd_blk_i >> 4);
            rword_q <= rd_blk_i[3:2];
         end
      end
   end

   assign mem_word = bank_q[rway_q][rbank_q][rword_q*32 +: 32];

`ifdef YSYX_041514_ICACHE_FWD_EN
   logic [BEAT_W-1:0] line_buf [BEATS];
   logic [CNT_W-1:0]  rd_beat;
   logic              fwd_sel_q;
   logic [31:0]       fwd_word_q;

   assign rd_beat = CNT_W'(rd_blk_i >> BEAT_LOG);
   // Only beats already received (index below beat_cnt) are safe to forward.
   assign fwd_hit = (rd_way_i == fill_way_q) && (rd_index_i == fill_idx_q) &&
                    (rd_beat < beat_cnt_q);

   always_ff @(posedge clk) begin
      if (rst || fill_accept) begin
         for (int i = 0; i < BEATS; i++) line_buf[i] <= '0;
      end else if (fill_fire) begin
         line_buf[beat_cnt_q] <= fill_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_sel_q  <= 1'b0;
         fwd_word_q <= '0;
      end else begin
         fwd_sel_q <= rd_fire & (state_q == S_FILL);
         if (rd_fire && state_q == S_FILL)
            fwd_word_q <= line_buf[rd_beat][rd_blk_i[BEAT_LOG-1:2]*32 +: 32];
      end
   end

   assign rd_word = fwd_sel_q ? fwd_word_q : mem_word;
`else
   assign fwd_hit = 1'b0;
   assign rd_word = mem_word;
`endif

   logic unused_blk_lsb;
   assign unused_blk_lsb = &{1'b0, rd_blk_i[1:0]};

   assign rdata_valid_o = rvalid_q;
   assign rdata_o       = rvalid_q ? {{($bits(rdata_o) - 32){1'b0}}, rd_word} : '0;
endmodule
